// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional WAIT-state abort timer enabled by defining TX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer; pick next requester round-robin
// LOAD  | winner's byte on data_in, settling one cycle
// START | tx_start pulse high for this cycle
// WAIT  | hold data_in until tx_done (or timeout)
// DONE  | ack pulse to winner, advance round-robin pointer
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BYTE_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*BYTE_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [BYTE_WIDTH-1:0]         data_in,
  output logic                          tx_start,
  input  logic                          tx_done,
  output logic                          timeout_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  if (NUM_REQ < 2 || NUM_REQ > 16 || BYTE_WIDTH < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter set");
  end

  logic [2:0]            state;
  logic [GW-1:0]         last_grant;
  logic                  found;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic [BYTE_WIDTH-1:0] pick_byte;

  // Search starts one past the last winner; wrap is explicit so non-power-of-two counts work.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) pick_byte = req_data[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= LAST_IDX;
      grant_id   <= '0;
      data_in    <= '0;
      tx_start   <= 1'b0;
      ack        <= '0;
      busy       <= 1'b0;
`ifdef TX_TIMEOUT_EN
      wait_cnt   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      ack      <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            state    <= S_LOAD;
            grant_id <= pick;
            data_in  <= pick_byte;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          state    <= S_START;
          tx_start <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
`ifdef TX_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (tx_done) begin
            state         <= S_DONE;
            ack[grant_id] <= 1'b1;
          end
`ifdef TX_TIMEOUT_EN
          // Abort still acks so a dead UART cannot lock out the requester.
          else if (wait_cnt == WAIT_LIMIT) begin
            state         <= S_DONE;
            ack[grant_id] <= 1'b1;
            timeout_q     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state      <= S_IDLE;
          last_grant <= grant_id;
          busy       <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, wrap/fairness, reset, spurious done, timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  data_in;
  logic        tx_start;
  logic        tx_done;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .BYTE_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .data_in(data_in), .tx_start(tx_start),
    .tx_done(tx_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle with the request already presented; returns in the following IDLE cycle.
  task automatic frame(input int id, input logic [7:0] exp_byte, input int delay, input bit drop);
    tick();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_grant", 32'(grant_id), 32'(id));
    chk("load_data", 32'(data_in), 32'(exp_byte));
    chk("load_start_low", 32'(tx_start), 32'd0);
    if (drop) begin
      req      = '0;
      req_data = '0;
    end
    tick();
    chk("start_pulse", 32'(tx_start), 32'd1);
    chk("start_data", 32'(data_in), 32'(exp_byte));
    tick();
    chk("wait_start_low", 32'(tx_start), 32'd0);
    repeat (delay) tick();
    chk("wait_no_ack", 32'(ack), 32'd0);
    chk("wait_data", 32'(data_in), 32'(exp_byte));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("done_ack", 32'(ack), 32'd1 << id);
    chk("done_busy", 32'(busy), 32'd1);
    tick();
    chk("idle_ack", 32'(ack), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_data_hold", 32'(data_in), 32'(exp_byte));
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    tx_done  = 1'b0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick();

    // Single request; requester drops req and data after grant, transfer still completes
    req      = 4'b0001;
    req_data = 32'h0000_00A5;
    frame(0, 8'hA5, 10, 1'b1);

    // Fresh pointer, all four requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data = 32'h4433_2211;
    req      = 4'b1111;
    frame(0, 8'h11, 1, 1'b0);
    frame(1, 8'h22, 0, 1'b0);
    frame(2, 8'h33, 2, 1'b0);
    frame(3, 8'h44, 1, 1'b0);

    // Wrap 3 -> 0, then 0 re-requesting immediately loses to pending 3
    req = 4'b1001;
    frame(0, 8'h11, 1, 1'b0);
    frame(3, 8'h44, 1, 1'b0);
    req = 4'b0001;
    frame(0, 8'h11, 1, 1'b0);
    req = 4'b0000;
    tick();
    chk("idle_no_req_busy", 32'(busy), 32'd0);
    chk("idle_no_req_data", 32'(data_in), 32'h11);

    // Reset during WAIT
    req = 4'b0100;
    tick();
    chk("rw_grant", 32'(grant_id), 32'd2);
    tick();
    tick();
    chk("rw_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_ack", 32'(ack), 32'd0);
    chk("rw_tx_start", 32'(tx_start), 32'd0);
    chk("rw_data_in", 32'(data_in), 32'd0);
    chk("rw_grant_id", 32'(grant_id), 32'd0);
    rst     = 1'b0;
    req     = 4'b0000;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("rw_late_done_ack", 32'(ack), 32'd0);
    chk("rw_late_done_busy", 32'(busy), 32'd0);

    // Spurious tx_done in IDLE and in START
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("sp_idle_busy", 32'(busy), 32'd0);
    chk("sp_idle_ack", 32'(ack), 32'd0);
    req = 4'b0010;
    tick();
    chk("sp_grant", 32'(grant_id), 32'd1);
    chk("sp_data", 32'(data_in), 32'h22);
    tick();
    chk("sp_start", 32'(tx_start), 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("sp_start_ack", 32'(ack), 32'd0);
    tick();
    chk("sp_still_wait_busy", 32'(busy), 32'd1);
    chk("sp_still_wait_ack", 32'(ack), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("sp_real_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    tick();
    chk("sp_idle_after", 32'(busy), 32'd0);

    // No tx_done at all: timeout with the macro, indefinite wait without
    req = 4'b0001;
    tick();
    chk("to_grant", 32'(grant_id), 32'd0);
    tick();
    tick();
    repeat (15) tick();
    chk("to_pre_busy", 32'(busy), 32'd1);
    chk("to_pre_ack", 32'(ack), 32'd0);
    chk("to_pre_err", 32'(timeout_err), 32'd0);
    tick();
`ifdef TX_TIMEOUT_EN
    chk("to_ack", 32'(ack), 32'b0001);
    chk("to_err", 32'(timeout_err), 32'd1);
    req = 4'b0000;
    tick();
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    chk("to_idle_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_err_cleared", 32'(timeout_err), 32'd0);
`else
    chk("nto_ack", 32'(ack), 32'd0);
    chk("nto_busy", 32'(busy), 32'd1);
    chk("nto_err", 32'(timeout_err), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("nto_late_ack", 32'(ack), 32'b0001);
    req = 4'b0000;
    tick();
    chk("nto_idle_busy", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
